// File: rtl/spiker_result_collector_if.sv
// Bus between the spike reader side and the result collector: step inputs, SW controls and result outputs.
interface spiker_result_collector_if #(
  parameter int N_OUT = 10,
  parameter int CNT_W = 8
);
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                   start;
  logic                   sample;
  logic [N_OUT-1:0]       spikes;
  logic                   ack;
  logic                   irq_en;
  logic [N_OUT*CNT_W-1:0] counts;
  logic [IDX_W-1:0]       class_idx;
  logic [CNT_W-1:0]       max_cnt;
  logic                   busy;
  logic                   done;
  logic                   irq;
  logic                   timeout;

  modport master (
    output start, sample, spikes, ack, irq_en,
    input  counts, class_idx, max_cnt, busy, done, irq, timeout
  );

  modport slave (
    input  start, sample, spikes, ack, irq_en,
    output counts, class_idx, max_cnt, busy, done, irq, timeout
  );
endinterface

// File: rtl/spiker_result_collector.sv
// Spike-count accumulator with sequential argmax over the output neurons.
// Optional RUN watchdog enabled by defining SPIKER_COLLECT_TIMEOUT_EN.
module spiker_result_collector #(
  parameter int N_OUT       = 10,
  parameter int CNT_W       = 8,
  parameter int N_STEPS     = 24,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  spiker_result_collector_if.slave bus
);
  localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int STEP_W = $clog2(N_STEPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, ARGMAX, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt [N_OUT];
  logic [STEP_W-1:0] step_cnt;
  logic [IDX_W-1:0]  idx, best_idx, class_q;
  logic [CNT_W-1:0]  best, max_q, cur;
  logic              irq_q, take, last_step, timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  // Argmax compare: index 0 seeds the best; later indices need a strictly larger count
  always_comb begin
    cur       = cnt[idx];
    take      = (idx == '0) || (cur > best);
    last_step = bus.sample && (step_cnt == STEP_W'(N_STEPS - 1));
  end

  always_comb begin
    state_nxt = state;
    if (bus.start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (last_step || timeout_hit) state_nxt = ARGMAX;
        ARGMAX:  if (idx == IDX_W'(N_OUT - 1)) state_nxt = DONE;
        DONE:    if (bus.ack) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      step_cnt <= '0;
      idx      <= '0;
      best     <= '0;
      best_idx <= '0;
      class_q  <= '0;
      max_q    <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
    end else begin
      state <= state_nxt;
      irq_q <= (state_nxt == DONE) && (state != DONE) && bus.irq_en;
      if (bus.start) begin
        step_cnt <= '0;
        idx      <= '0;
        best     <= '0;
        best_idx <= '0;
        class_q  <= '0;
        max_q    <= '0;
        for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
      end else begin
        case (state)
          RUN: begin
            idx <= '0;
            if (bus.sample) begin
              for (int i = 0; i < N_OUT; i++) cnt[i] <= sat_inc(cnt[i], bus.spikes[i]);
              step_cnt <= step_cnt + 1'b1;
            end
          end
          ARGMAX: begin
            if (take) begin
              best     <= cur;
              best_idx <= idx;
            end
            idx <= idx + 1'b1;
            // Last neuron: the result must include this cycle's comparison
            if (idx == IDX_W'(N_OUT - 1)) begin
              class_q <= take ? idx : best_idx;
              max_q   <= take ? cur : best;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPIKER_COLLECT_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              to_q;

  assign timeout_hit = (state == RUN) && !bus.sample && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_cnt <= '0;
      to_q     <= 1'b0;
    end else begin
      if (bus.start || bus.sample || (state != RUN)) idle_cnt <= '0;
      else                                           idle_cnt <= idle_cnt + 1'b1;
      if (bus.start)        to_q <= 1'b0;
      else if (timeout_hit) to_q <= 1'b1;
    end
  end

  assign bus.timeout = to_q;
`else
  // Watchdog compiled out: RUN waits for samples indefinitely and the flag is constant 0
  assign timeout_hit = 1'b0;
  assign bus.timeout = (TIMEOUT_CYC < 0);
`endif

  for (genvar i = 0; i < N_OUT; i++) begin : g_counts
    assign bus.counts[(i+1)*CNT_W-1 -: CNT_W] = cnt[i];
  end

  assign bus.class_idx = class_q;
  assign bus.max_cnt   = max_q;
  assign bus.busy      = (state == RUN) || (state == ARGMAX);
  assign bus.done      = (state == DONE);
  assign bus.irq       = irq_q;
endmodule

// File: tb/tb_spiker_result_collector.sv
// Scoreboard bench: two collector instances (CNT_W=8 and CNT_W=4) sharing clock and reset.
module tb_spiker_result_collector;
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  spiker_result_collector_if #(.N_OUT(10), .CNT_W(8)) ifa ();
  spiker_result_collector_if #(.N_OUT(10), .CNT_W(4)) ifb ();

  spiker_result_collector #(.N_OUT(10), .CNT_W(8), .N_STEPS(24), .TIMEOUT_CYC(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .bus(ifa));
  spiker_result_collector #(.N_OUT(10), .CNT_W(4), .N_STEPS(24), .TIMEOUT_CYC(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .bus(ifb));

  typedef struct {
    logic [3:0]  cls;
    logic [7:0]  maxc;
    logic [79:0] counts;
    logic        irq;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic done_a_q = 1'b0, done_b_q = 1'b0, irq2_a = 1'b0, irq2_b = 1'b0;
  logic [79:0] ec;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [3:0] c, input logic [7:0] m, input logic [79:0] cn, input logic i);
    exp_t e;
    e.cls = c; e.maxc = m; e.counts = cn; e.irq = i;
    qa.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_a();
    ifa.start = 1'b1; tick(); ifa.start = 1'b0;
  endtask

  task automatic ack_a();
    ifa.ack = 1'b1; tick(); ifa.ack = 1'b0;
  endtask

  task automatic samples_a(input logic [9:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      ifa.sample = 1'b1; ifa.spikes = pat; tick();
    end
    ifa.sample = 1'b0; ifa.spikes = '0;
  endtask

  // Called right after the capture edge of the last sample; that cycle counts as 1
  task automatic wait_done_a(input string name, input logic check_lat);
    int n;
    n = 1;
    while (!ifa.done && n < 100) begin tick(); n++; end
    if (check_lat) chk(name, 80'(n), 80'd11);
    else           chk(name, 80'(ifa.done), 80'd1);
  endtask

  // Monitors: pop one expectation per DONE entry; irq must drop on the second DONE cycle
  always @(negedge clk) begin
    if (rst_ni && ifa.done && !done_a_q) begin
      if (qa.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected_done: got done=1 expected no result pending");
      end else begin
        ea = qa.pop_front();
        chk("a_class", 80'(ifa.class_idx), 80'(ea.cls));
        chk("a_max", 80'(ifa.max_cnt), 80'(ea.maxc));
        chk("a_counts", ifa.counts, ea.counts);
        chk("a_irq_entry", 80'(ifa.irq), 80'(ea.irq));
      end
    end else if (ifa.done && done_a_q && !irq2_a) begin
      chk("a_irq_once", 80'(ifa.irq), 80'd0);
      irq2_a = 1'b1;
    end
    if (!ifa.done) irq2_a = 1'b0;
    done_a_q = ifa.done;
  end

  always @(negedge clk) begin
    if (rst_ni && ifb.done && !done_b_q) begin
      if (qb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected_done: got done=1 expected no result pending");
      end else begin
        eb = qb.pop_front();
        chk("b_class", 80'(ifb.class_idx), 80'(eb.cls));
        chk("b_max", 80'(ifb.max_cnt), 80'(eb.maxc));
        chk("b_counts", {40'b0, ifb.counts}, eb.counts);
        chk("b_irq_entry", 80'(ifb.irq), 80'(eb.irq));
      end
    end else if (ifb.done && done_b_q && !irq2_b) begin
      chk("b_irq_once", 80'(ifb.irq), 80'd0);
      irq2_b = 1'b1;
    end
    if (!ifb.done) irq2_b = 1'b0;
    done_b_q = ifb.done;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    exp_t e;
    int   n;
    ifa.start = 0; ifa.sample = 0; ifa.spikes = '0; ifa.ack = 0; ifa.irq_en = 1;
    ifb.start = 0; ifb.sample = 0; ifb.spikes = '0; ifb.ack = 0; ifb.irq_en = 1;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    tick();

    // Reset state
    chk("rst_counts", ifa.counts, 80'd0);
    chk("rst_class", 80'(ifa.class_idx), 80'd0);
    chk("rst_max", 80'(ifa.max_cnt), 80'd0);
    chk("rst_busy", 80'(ifa.busy), 80'd0);
    chk("rst_done", 80'(ifa.done), 80'd0);
    chk("rst_irq", 80'(ifa.irq), 80'd0);
    chk("rst_timeout", 80'(ifa.timeout), 80'd0);
    chk("rst_b_counts", {40'b0, ifb.counts}, 80'd0);

    // Reset in the middle of RUN discards the partial counts
    start_a();
    samples_a(10'h010, 5);
    chk("midrun_busy", 80'(ifa.busy), 80'd1);
    chk("midrun_count4", 80'(ifa.counts[39:32]), 80'd5);
    rst_ni = 1'b0;
    #2;
    chk("midrst_counts", ifa.counts, 80'd0);
    chk("midrst_busy", 80'(ifa.busy), 80'd0);
    chk("midrst_done", 80'(ifa.done), 80'd0);
    @(posedge clk); #1 rst_ni = 1'b1;
    tick();

    // Basic: neuron 3 spikes every step
    ec = '0; ec[8*3 +: 8] = 8'd24;
    push_a(4'd3, 8'd24, ec, 1'b1);
    start_a();
    samples_a(10'h008, 24);
    wait_done_a("lat_basic", 1'b1);
    repeat (3) tick();
    ack_a();
    chk("basic_ack_done", 80'(ifa.done), 80'd0);
    chk("basic_ack_busy", 80'(ifa.busy), 80'd0);

    // start with sample in the same cycle: that sample is dropped; ack in RUN ignored
    ec = '0; ec[8*1 +: 8] = 8'd24;
    push_a(4'd1, 8'd24, ec, 1'b1);
    ifa.start = 1'b1; ifa.sample = 1'b1; ifa.spikes = 10'h002;
    tick();
    ifa.start = 1'b0; ifa.sample = 1'b0; ifa.spikes = '0;
    samples_a(10'h002, 10);
    ack_a();
    chk("ack_in_run_busy", 80'(ifa.busy), 80'd1);
    samples_a(10'h002, 13);
    tick();
    chk("drop_busy_23", 80'(ifa.busy), 80'd1);
    chk("drop_count1_23", 80'(ifa.counts[15:8]), 80'd23);
    samples_a(10'h002, 1);
    wait_done_a("lat_drop", 1'b1);
    repeat (2) tick();

    // ack and start together in DONE: start wins
    ifa.start = 1'b1; ifa.ack = 1'b1;
    tick();
    ifa.start = 1'b0; ifa.ack = 1'b0;
    chk("ackstart_busy", 80'(ifa.busy), 80'd1);
    chk("ackstart_done", 80'(ifa.done), 80'd0);
    chk("ackstart_counts", ifa.counts, 80'd0);

    // irq disabled; neuron 9 beats neuron 0 only after the first half
    ifa.irq_en = 1'b0;
    ec = '0; ec[8*0 +: 8] = 8'd12; ec[8*9 +: 8] = 8'd24;
    push_a(4'd9, 8'd24, ec, 1'b0);
    samples_a(10'h201, 12);
    samples_a(10'h200, 12);
    wait_done_a("lat_noirq", 1'b1);
    repeat (3) tick();
    chk("noirq_done_held", 80'(ifa.done), 80'd1);
    ack_a();
    chk("noirq_ack_done", 80'(ifa.done), 80'd0);
    ifa.irq_en = 1'b1;

    // Restart after 10 samples clears counts and the step count
    start_a();
    samples_a(10'h020, 10);
    start_a();
    samples_a(10'h040, 23);
    tick();
    chk("restart_busy_23", 80'(ifa.busy), 80'd1);
    ec = '0; ec[8*6 +: 8] = 8'd24;
    push_a(4'd6, 8'd24, ec, 1'b1);
    samples_a(10'h040, 1);
    wait_done_a("lat_restart", 1'b1);
    ack_a();

    // Silence after 5 samples
    start_a();
    samples_a(10'h008, 5);
`ifdef SPIKER_COLLECT_TIMEOUT_EN
    ec = '0; ec[8*3 +: 8] = 8'd5;
    push_a(4'd3, 8'd5, ec, 1'b1);
    wait_done_a("timeout_done", 1'b0);
    chk("timeout_flag", 80'(ifa.timeout), 80'd1);
    ack_a();
    chk("timeout_sticky_idle", 80'(ifa.timeout), 80'd1);
    start_a();
    chk("timeout_cleared", 80'(ifa.timeout), 80'd0);
    rst_ni = 1'b0; #2; rst_ni = 1'b1;
    tick();
`else
    repeat (40) tick();
    chk("silence_busy", 80'(ifa.busy), 80'd1);
    chk("silence_timeout", 80'(ifa.timeout), 80'd0);
    chk("silence_done", 80'(ifa.done), 80'd0);
    ec = '0; ec[8*3 +: 8] = 8'd24;
    push_a(4'd3, 8'd24, ec, 1'b1);
    samples_a(10'h008, 19);
    wait_done_a("lat_silence", 1'b1);
    ack_a();
`endif

    // Saturation and tie on the 4-bit instance: neurons 2 and 7 both reach 15
    e.cls = 4'd2; e.maxc = 8'd15; e.counts = {40'b0, 40'h00F0000F00}; e.irq = 1'b1;
    qb.push_back(e);
    ifb.start = 1'b1; tick(); ifb.start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      ifb.sample = 1'b1; ifb.spikes = 10'h084; tick();
    end
    ifb.sample = 1'b0; ifb.spikes = '0;
    n = 1;
    while (!ifb.done && n < 100) begin tick(); n++; end
    chk("lat_b_tie", 80'(n), 80'd11);
    repeat (2) tick();
    ifb.ack = 1'b1; tick(); ifb.ack = 1'b0;
    chk("b_ack_done", 80'(ifb.done), 80'd0);

    repeat (3) tick();
    chk("qa_drained", 80'(qa.size()), 80'd0);
    chk("qb_drained", 80'(qb.size()), 80'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
